// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU operation codes, forwarding selects and
// the ID/EX control bundle. Decode and execute must agree on these encodings.
package pipeline_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } idex_ctrl_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, subtract, AND, OR and signed set-less-than.
// Unused operation codes yield zero.
module alu
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  logic [WIDTH-1:0] diff;
  logic             lt;

  // Signs decide when they differ, so an overflowing a - b cannot flip the result.
  always_comb begin
    diff = a + ~b + 1'b1;
    lt   = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];
  end

  always_comb begin
    y = '0;
    case (alucontrol)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = diff;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX pipeline register, operand forwarding, ALU and
// destination register selection feeding the EX/MEM register.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic               regwrite_d,
  input  logic               memtoreg_d,
  input  logic               memwrite_d,
  input  logic               alusrc_d,
  input  logic               regdst_d,
  input  logic [2:0]         alucontrol_d,
  input  logic [WIDTH-1:0]   rd1_d,
  input  logic [WIDTH-1:0]   rd2_d,
  input  logic [WIDTH-1:0]   signimm_d,
  input  logic [REGBITS-1:0] rs_d,
  input  logic [REGBITS-1:0] rt_d,
  input  logic [REGBITS-1:0] rd_d,
  input  logic [1:0]         forward_a_e,
  input  logic [1:0]         forward_b_e,
  input  logic [WIDTH-1:0]   aluout_m,
  input  logic [WIDTH-1:0]   result_w,
  output logic               regwrite_e,
  output logic               memtoreg_e,
  output logic               memwrite_e,
  output logic [REGBITS-1:0] rs_e,
  output logic [REGBITS-1:0] rt_e,
  output logic [REGBITS-1:0] writereg_e,
  output logic [WIDTH-1:0]   aluout_e,
  output logic [WIDTH-1:0]   writedata_e,
  output logic               zero_e
);

  idex_ctrl_t         ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   rd1_q, rd2_q, signimm_q;
  logic [REGBITS-1:0] rs_q, rt_q, rd_q;
  logic [WIDTH-1:0]   srca, fwdb, srcb;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.regwrite   = regwrite_d;
    ctrl_d.memtoreg   = memtoreg_d;
    ctrl_d.memwrite   = memwrite_d;
    ctrl_d.alusrc     = alusrc_d;
    ctrl_d.regdst     = regdst_d;
    ctrl_d.alucontrol = alucontrol_d;
  end

  // Flush takes precedence over stall so a squashed instruction never lingers.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      ctrl_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      signimm_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else if (!stall_e) begin
      ctrl_q    <= ctrl_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      signimm_q <= signimm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  // The unused select 2'b11 falls back to the register-file value.
  always_comb begin
    case (forward_a_e)
      FWD_WB:  srca = result_w;
      FWD_MEM: srca = aluout_m;
      default: srca = rd1_q;
    endcase
    case (forward_b_e)
      FWD_WB:  fwdb = result_w;
      FWD_MEM: fwdb = aluout_m;
      default: fwdb = rd2_q;
    endcase
    srcb = ctrl_q.alusrc ? signimm_q : fwdb;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a          (srca),
    .b          (srcb),
    .alucontrol (ctrl_q.alucontrol),
    .y          (aluout_e),
    .zero       (zero_e)
  );

  assign regwrite_e  = ctrl_q.regwrite;
  assign memtoreg_e  = ctrl_q.memtoreg;
  assign memwrite_e  = ctrl_q.memwrite;
  assign rs_e        = rs_q;
  assign rt_e        = rt_q;
  assign writereg_e  = ctrl_q.regdst ? rd_q : rt_q;
  assign writedata_e = fwdb;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e;
  logic        regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
  logic [2:0]  alucontrol_d;
  logic [31:0] rd1_d, rd2_d, signimm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [31:0] aluout_m, result_w;
  logic        regwrite_e, memtoreg_e, memwrite_e;
  logic [4:0]  rs_e, rt_e, writereg_e;
  logic [31:0] aluout_e, writedata_e;
  logic        zero_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_e      (stall_e),
    .flush_e      (flush_e),
    .regwrite_d   (regwrite_d),
    .memtoreg_d   (memtoreg_d),
    .memwrite_d   (memwrite_d),
    .alusrc_d     (alusrc_d),
    .regdst_d     (regdst_d),
    .alucontrol_d (alucontrol_d),
    .rd1_d        (rd1_d),
    .rd2_d        (rd2_d),
    .signimm_d    (signimm_d),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rd_d         (rd_d),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .aluout_m     (aluout_m),
    .result_w     (result_w),
    .regwrite_e   (regwrite_e),
    .memtoreg_e   (memtoreg_e),
    .memwrite_e   (memwrite_e),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .writereg_e   (writereg_e),
    .aluout_e     (aluout_e),
    .writedata_e  (writedata_e),
    .zero_e       (zero_e)
  );

  typedef struct packed {
    logic        regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  typedef struct packed {
    instr_t      in;
    logic [1:0]  fa, fb;
    logic [31:0] expAlu, expWd;
    logic [4:0]  expWr;
    logic        expZero;
  } vec_t;

  instr_t curIn;
  instr_t mdl;

  function automatic instr_t mkIn(logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                                  logic [2:0] alu, logic alusrc, logic regdst,
                                  logic [4:0] rt, logic [4:0] rd);
    instr_t t;
    t = '0;
    t.regwrite = 1'b1;
    t.alusrc   = alusrc;
    t.regdst   = regdst;
    t.alu      = alu;
    t.rd1      = rd1;
    t.rd2      = rd2;
    t.imm      = imm;
    t.rs       = 5'd1;
    t.rt       = rt;
    t.rd       = rd;
    return t;
  endfunction

  function automatic logic [31:0] fwdVal(logic [1:0] sel, logic [31:0] rf);
    if (sel == 2'b01) return result_w;
    if (sel == 2'b10) return aluout_m;
    return rf;
  endfunction

  function automatic logic [31:0] refAlu(instr_t m);
    logic [31:0] a, b;
    a = fwdVal(forward_a_e, m.rd1);
    b = m.alusrc ? m.imm : fwdVal(forward_b_e, m.rd2);
    case (m.alu)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(instr_t s);
    curIn        = s;
    regwrite_d   = s.regwrite;
    memtoreg_d   = s.memtoreg;
    memwrite_d   = s.memwrite;
    alusrc_d     = s.alusrc;
    regdst_d     = s.regdst;
    alucontrol_d = s.alu;
    rd1_d        = s.rd1;
    rd2_d        = s.rd2;
    signimm_d    = s.imm;
    rs_d         = s.rs;
    rt_d         = s.rt;
    rd_d         = s.rd;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset || flush_e) mdl = '0;
    else if (!stall_e)    mdl = curIn;
    @(negedge clk);
  endtask

  task automatic checkOutput(string tag);
    logic [31:0] expAlu;
    expAlu = refAlu(mdl);
    checkVal({tag, ".regwrite"},  {31'd0, regwrite_e}, {31'd0, mdl.regwrite});
    checkVal({tag, ".memtoreg"},  {31'd0, memtoreg_e}, {31'd0, mdl.memtoreg});
    checkVal({tag, ".memwrite"},  {31'd0, memwrite_e}, {31'd0, mdl.memwrite});
    checkVal({tag, ".rs"},        {27'd0, rs_e}, {27'd0, mdl.rs});
    checkVal({tag, ".rt"},        {27'd0, rt_e}, {27'd0, mdl.rt});
    checkVal({tag, ".writereg"},  {27'd0, writereg_e}, {27'd0, (mdl.regdst ? mdl.rd : mdl.rt)});
    checkVal({tag, ".aluout"},    aluout_e, expAlu);
    checkVal({tag, ".writedata"}, writedata_e, fwdVal(forward_b_e, mdl.rd2));
    checkVal({tag, ".zero"},      {31'd0, zero_e}, {31'd0, (expAlu == 32'd0)});
  endtask

  vec_t   vecs[14];
  instr_t tmp;

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    forward_a_e = 2'b00; forward_b_e = 2'b00;
    aluout_m = 32'h10; result_w = 32'h20;
    mdl = '0;
    applyStimulus('0);

    vecs[0]  = '{mkIn(32'd7, 32'd5, 32'd0, 3'b110, 1'b0, 1'b1, 5'd3, 5'd9), 2'b00, 2'b00, 32'd2, 32'd5, 5'd9, 1'b0};
    vecs[1]  = '{mkIn(32'h8000_0000, 32'd1, 32'd0, 3'b111, 1'b0, 1'b0, 5'd4, 5'd8), 2'b00, 2'b00, 32'd1, 32'd1, 5'd4, 1'b0};
    vecs[2]  = '{mkIn(32'd4, 32'h55, 32'hFFFF_FFFC, 3'b010, 1'b1, 1'b0, 5'd6, 5'd2), 2'b00, 2'b00, 32'd0, 32'h55, 5'd6, 1'b1};
    vecs[3]  = '{mkIn(32'd1, 32'd0, 32'd0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0), 2'b10, 2'b00, 32'h10, 32'd0, 5'd0, 1'b0};
    vecs[4]  = '{mkIn(32'd1, 32'd0, 32'd0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0), 2'b01, 2'b00, 32'h20, 32'd0, 5'd0, 1'b0};
    vecs[5]  = '{mkIn(32'd1, 32'd0, 32'd0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0), 2'b11, 2'b00, 32'd1, 32'd0, 5'd0, 1'b0};
    vecs[6]  = '{mkIn(32'd1, 32'd0, 32'd0, 3'b010, 1'b1, 1'b0, 5'd0, 5'd0), 2'b00, 2'b10, 32'd1, 32'h10, 5'd0, 1'b0};
    vecs[7]  = '{mkIn(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 3'b111, 1'b0, 1'b1, 5'd2, 5'd31), 2'b00, 2'b00, 32'd0, 32'hFFFF_FFFF, 5'd31, 1'b1};
    vecs[8]  = '{mkIn(32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 3'b110, 1'b0, 1'b0, 5'd7, 5'd1), 2'b00, 2'b00, 32'd1, 32'h7FFF_FFFF, 5'd7, 1'b0};
    vecs[9]  = '{mkIn(32'hF0, 32'h0F, 32'd0, 3'b001, 1'b0, 1'b0, 5'd5, 5'd1), 2'b00, 2'b00, 32'hFF, 32'h0F, 5'd5, 1'b0};
    vecs[10] = '{mkIn(32'hF0, 32'h0F, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 5'd1), 2'b00, 2'b00, 32'd0, 32'h0F, 5'd5, 1'b1};
    vecs[11] = '{mkIn(32'hF0, 32'h0F, 32'd0, 3'b011, 1'b0, 1'b0, 5'd5, 5'd1), 2'b00, 2'b00, 32'd0, 32'h0F, 5'd5, 1'b1};
    vecs[12] = '{mkIn(32'hF0, 32'h0F, 32'd0, 3'b100, 1'b0, 1'b1, 5'd5, 5'd12), 2'b00, 2'b11, 32'd0, 32'h0F, 5'd12, 1'b1};
    vecs[13] = '{mkIn(32'hFFFF_FFFF, 32'd1, 32'd0, 3'b101, 1'b0, 1'b0, 5'd5, 5'd1), 2'b00, 2'b01, 32'd0, 32'h20, 5'd5, 1'b1};

    @(negedge clk);
    cycle();
    reset = 1'b0;
    checkVal("rst.regwrite",  {31'd0, regwrite_e}, 32'd0);
    checkVal("rst.memwrite",  {31'd0, memwrite_e}, 32'd0);
    checkVal("rst.memtoreg",  {31'd0, memtoreg_e}, 32'd0);
    checkVal("rst.aluout",    aluout_e, 32'd0);
    checkVal("rst.zero",      {31'd0, zero_e}, 32'd1);
    checkVal("rst.writereg",  {27'd0, writereg_e}, 32'd0);
    checkVal("rst.writedata", writedata_e, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].in);
      forward_a_e = vecs[i].fa;
      forward_b_e = vecs[i].fb;
      cycle();
      checkVal($sformatf("vec%0d.aluout", i),    aluout_e, vecs[i].expAlu);
      checkVal($sformatf("vec%0d.writedata", i), writedata_e, vecs[i].expWd);
      checkVal($sformatf("vec%0d.writereg", i),  {27'd0, writereg_e}, {27'd0, vecs[i].expWr});
      checkVal($sformatf("vec%0d.zero", i),      {31'd0, zero_e}, {31'd0, vecs[i].expZero});
      checkOutput($sformatf("vec%0d", i));
    end
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;

    // Stall holds instruction A while decode inputs change, then flush+stall bubbles.
    tmp = mkIn(32'd3, 32'd4, 32'd0, 3'b010, 1'b0, 1'b1, 5'd2, 5'd11);
    tmp.memwrite = 1'b1;
    applyStimulus(tmp);
    cycle();
    checkVal("stallA.aluout", aluout_e, 32'd7);
    stall_e = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(mkIn(32'd100 + k, 32'd9, 32'd0, 3'b110, 1'b0, 1'b0, 5'd20, 5'd21));
      cycle();
      checkVal("stall.aluout",   aluout_e, 32'd7);
      checkVal("stall.writereg", {27'd0, writereg_e}, 32'd11);
      checkVal("stall.memwrite", {31'd0, memwrite_e}, 32'd1);
    end
    flush_e = 1'b1;
    cycle();
    stall_e = 1'b0;
    flush_e = 1'b0;
    checkVal("flush.regwrite", {31'd0, regwrite_e}, 32'd0);
    checkVal("flush.memwrite", {31'd0, memwrite_e}, 32'd0);
    checkVal("flush.aluout",   aluout_e, 32'd0);
    checkVal("flush.zero",     {31'd0, zero_e}, 32'd1);

    // Mid-stream reset discards the in-flight instruction.
    tmp = mkIn(32'd8, 32'd8, 32'd0, 3'b001, 1'b0, 1'b1, 5'd3, 5'd13);
    tmp.memwrite = 1'b1;
    applyStimulus(tmp);
    cycle();
    checkVal("pre_rst.memwrite", {31'd0, memwrite_e}, 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkVal("midrst.regwrite", {31'd0, regwrite_e}, 32'd0);
    checkVal("midrst.memwrite", {31'd0, memwrite_e}, 32'd0);
    checkVal("midrst.aluout",   aluout_e, 32'd0);
    checkVal("midrst.writereg", {27'd0, writereg_e}, 32'd0);
    applyStimulus(mkIn(32'd20, 32'd6, 32'd0, 3'b110, 1'b0, 1'b0, 5'd14, 5'd15));
    cycle();
    checkVal("postrst.aluout",   aluout_e, 32'd14);
    checkVal("postrst.writereg", {27'd0, writereg_e}, 32'd14);
    checkVal("postrst.regwrite", {31'd0, regwrite_e}, 32'd1);

    for (int n = 0; n < 400; n++) begin
      tmp          = instr_t'({$urandom, $urandom, $urandom, $urandom});
      tmp.alu      = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) tmp.rd1 = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) tmp.rd2 = tmp.rd1;
      applyStimulus(tmp);
      stall_e     = ($urandom_range(0, 7) == 0);
      flush_e     = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 24) == 0);
      forward_a_e = 2'($urandom_range(0, 3));
      forward_b_e = 2'($urandom_range(0, 3));
      aluout_m    = $urandom;
      result_w    = $urandom;
      cycle();
      checkOutput($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
